mem_arb: RTL and testbench
==========================

MEM_ARB -- requirements
Module: mem_arb

Interface
REQ-001 Parameters SHALL be: SIZE, default 100, words in attached memory; WIDTH, default 36, word bits; NBYTES, default 3, write lanes (WIDTH/NBYTES bits each); ADDR_WIDTH, default $clog2(SIZE-1)+1, address bits.
REQ-002 All vectors SHALL be big-endian [0:n-1]; lane-enable bit 0 selects the leftmost lane.
REQ-003 One clock; reset is synchronous and active-high (clk, reset).
REQ-004 clk  in  1  rising-edge clock.
REQ-005 reset  in  1  synchronous active-high reset.
REQ-006 req[0:1]  in  2  per-port access request, held until ack.
REQ-007 we[0:1]  in  2  per-port 1=write, 0=read.
REQ-008 addr0, addr1  in  ADDR_WIDTH  per-port word address.
REQ-009 wdata0, wdata1  in  WIDTH  per-port write data.
REQ-010 be0, be1  in  NBYTES  per-port lane enables.
REQ-011 ack[0:1]  out  2  one-cycle completion pulse.
REQ-012 err[0:1]  out  2  address-out-of-range flag, valid with ack.
REQ-013 rdata  out  WIDTH  shared read data, valid while any ack is high.
REQ-014 busy  out  1  high in GRANT and DONE.
REQ-015 mem_addr  out  ADDR_WIDTH  to memory.
REQ-016 mem_din  out  WIDTH  to memory.
REQ-017 mem_wea  out  NBYTES  to memory; writes on clk rising edge.
REQ-018 mem_dout  in  WIDTH  combinational read of mem_addr.

Function
REQ-019 FSM SHALL have states IDLE, GRANT, DONE.
REQ-020 IDLE: if any req, SHALL pick winner, latch its we/addr/wdata/be, record winner, go GRANT; else stay.
REQ-021 Arbitration SHALL be round-robin: sole requester wins; with both requesting, the port not most recently granted wins.
REQ-022 GRANT: mem_addr/mem_din SHALL come from latched values; mem_wea SHALL equal latched be only for an in-range write, else 0; rdata register SHALL capture mem_dout (pre-write contents) at cycle end; go DONE.
REQ-023 DONE: ack of winner only SHALL be high exactly this cycle; err high with it if latched addr >= SIZE; go IDLE.
REQ-024 Latency: req seen in IDLE at cycle N -> memory write at end of N+1 -> ack in N+2; throughput one access per 3 cycles.
REQ-025 Out-of-range access SHALL not write, SHALL return rdata=0, SHALL still ack.
REQ-026 Write with be=0 SHALL perform no write and ack with current contents.
REQ-027 req dropped after grant SHALL not abort: access completes and ack still pulses.
REQ-028 Request arriving in GRANT/DONE SHALL wait; it is considered in next IDLE.
REQ-029 mem_wea SHALL be 0 in every state except GRANT.
REQ-030 rdata SHALL hold its value between accesses.

Reset
REQ-031 reset SHALL force state IDLE, ack=0, err=0, busy=0, mem_wea=0, rdata=0, last-grant=port 1 (port 0 wins first tie).
REQ-032 reset asserted in GRANT SHALL suppress the memory write that cycle and drop the pending access without ack.

Structure
REQ-033 State enum and port-count constant (2) SHALL live in shared package mem_pkg.
REQ-034 Round-robin pick SHALL be sub-module rr_pick2 (inputs req, last; output grant index); rest flat.

Verification
REQ-035 Bench SHALL attach sim_mem (SIZE=100, WIDTH=36, NBYTES=3) and preload mem['h13]=36'h123456789.
REQ-036 Port0 read 'h13 -> ack0 two cycles after grant, rdata=36'h123456789, err0=0.
REQ-037 Port1 write 'h7=36'h111111111 be=111, then write 36'h222dddccc be=100, then read 'h7 -> rdata=36'h222111111.
REQ-038 Both ports request in same cycle, held continuously -> grants alternate 0,1,0,1; no double ack.
REQ-039 Port0 write addr 'd100 -> ack0 with err0=1, rdata=0, mem_wea never nonzero.
REQ-040 reset asserted in GRANT of write 'h7=36'heeeeeeeee -> mem['h7] unchanged, no ack, next access from IDLE succeeds.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared FSM state type and port count for the two-port memory arbiter.
package mem_pkg;

    localparam int N_PORTS = 2;

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        DONE
    } state_e;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin pick: a sole requester wins, a tie goes to the port
// that was not granted most recently.
module rr_pick2
    import mem_pkg::*;
(
    input  logic [0:N_PORTS-1] req,
    input  logic               last,
    output logic               grant
);

    always_comb begin
        if (req[0] && req[1]) begin
            grant = ~last;
        end else begin
            grant = ~req[0];
        end
    end

endmodule

// File: rtl/mem_arb.sv
// Two-port round-robin arbiter in front of a single-port byte-lane memory;
// one access per IDLE -> GRANT -> DONE pass, acked in DONE.
module mem_arb
    import mem_pkg::*;
#(
    parameter int SIZE       = 100,
    parameter int WIDTH      = 36,
    parameter int NBYTES     = 3,
    parameter int ADDR_WIDTH = $clog2(SIZE - 1) + 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [0:N_PORTS-1]    req,
    input  logic [0:N_PORTS-1]    we,
    input  logic [0:ADDR_WIDTH-1] addr0,
    input  logic [0:ADDR_WIDTH-1] addr1,
    input  logic [0:WIDTH-1]      wdata0,
    input  logic [0:WIDTH-1]      wdata1,
    input  logic [0:NBYTES-1]     be0,
    input  logic [0:NBYTES-1]     be1,
    output logic [0:N_PORTS-1]    ack,
    output logic [0:N_PORTS-1]    err,
    output logic [0:WIDTH-1]      rdata,
    output logic                  busy,
    output logic [0:ADDR_WIDTH-1] mem_addr,
    output logic [0:WIDTH-1]      mem_din,
    output logic [0:NBYTES-1]     mem_wea,
    input  logic [0:WIDTH-1]      mem_dout
);

    localparam logic [0:ADDR_WIDTH-1] LIMIT = ADDR_WIDTH'(SIZE);

    state_e                state;
    state_e                next_state;
    logic                  last;
    logic                  pick;
    logic                  in_range;
    logic                  lat_we;
    logic [0:ADDR_WIDTH-1] lat_addr;
    logic [0:WIDTH-1]      lat_wdata;
    logic [0:NBYTES-1]     lat_be;

    rr_pick2 u_pick (
        .req  (req),
        .last (last),
        .grant(pick)
    );

    assign in_range = (lat_addr < LIMIT);
    assign mem_addr = lat_addr;
    assign mem_din  = lat_wdata;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        // NOTE: defaults first, so no path through the case leaves a signal unassigned (no latch).
        next_state = state;
        busy       = 1'b0;
        mem_wea    = '0;
        case (state)
            IDLE: begin
                if (|req) begin
                    next_state = GRANT;
                end
            end
            GRANT: begin
                busy       = 1'b1;
                next_state = DONE;
                // Reset in this cycle must also cancel the write landing on this edge.
                if (lat_we && in_range && !reset) begin
                    mem_wea = lat_be;
                end
            end
            DONE: begin
                busy       = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // NOTE: the latched request fields carry no reset; they are always loaded in IDLE before GRANT uses them.
    always_ff @(posedge clk) begin
        if (state == IDLE && |req) begin
            lat_we    <= we[pick];
            lat_addr  <= pick ? addr1 : addr0;
            lat_wdata <= pick ? wdata1 : wdata0;
            lat_be    <= pick ? be1 : be0;
        end
    end

    // last doubles as the winner of the access in flight, since it only moves on a grant.
    always_ff @(posedge clk) begin
        if (reset) begin
            last  <= 1'b1;
            ack   <= '0;
            err   <= '0;
            rdata <= '0;
        end else begin
            ack <= '0;
            err <= '0;
            if (state == IDLE && |req) begin
                last <= pick;
            end
            if (state == GRANT) begin
                ack[last] <= 1'b1;
                err[last] <= ~in_range;
                rdata     <= in_range ? mem_dout : '0;
            end
        end
    end

endmodule

// File: tb/tb_mem_arb.sv
// Self-checking bench for mem_arb: directed table, multi-cycle corner
// sequences and randomized accesses against a transaction-level model.
module tb_mem_arb;

    localparam int SIZE   = 100;
    localparam int WIDTH  = 36;
    localparam int NBYTES = 3;
    localparam int AW     = 8;
    localparam int LW     = WIDTH / NBYTES;

    typedef struct {
        logic [0:1]        r;
        logic [0:1]        w;
        logic [0:AW-1]     a0;
        logic [0:AW-1]     a1;
        logic [0:WIDTH-1]  d0;
        logic [0:WIDTH-1]  d1;
        logic [0:NBYTES-1] b0;
        logic [0:NBYTES-1] b1;
        int                port;
        logic              e;
        logic [0:WIDTH-1]  rd;
    } vec_t;

    logic              clk = 1'b0;
    logic              reset;
    logic [0:1]        req, we, ack, err;
    logic [0:AW-1]     addr0, addr1, mem_addr;
    logic [0:WIDTH-1]  wdata0, wdata1, rdata, mem_din, mem_dout;
    logic [0:NBYTES-1] be0, be1, mem_wea;
    logic              busy;
    logic              mem_init;

    logic [0:WIDTH-1]  sim_mem [0:SIZE-1];
    logic [0:WIDTH-1]  ref_mem [0:SIZE-1];
    int                ref_last;
    int                n_vec = 0;
    int                n_err = 0;
    int                dbl_acks = 0;
    int                wea_idle = 0;

    always #5 clk = ~clk;

    mem_arb #(.SIZE(SIZE), .WIDTH(WIDTH), .NBYTES(NBYTES), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .reset(reset), .req(req), .we(we),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .be0(be0), .be1(be1), .ack(ack), .err(err), .rdata(rdata), .busy(busy),
        .mem_addr(mem_addr), .mem_din(mem_din), .mem_wea(mem_wea), .mem_dout(mem_dout)
    );

    // Attached memory; out-of-range reads return junk so the arbiter must zero them.
    assign mem_dout = (int'(mem_addr) < SIZE) ? sim_mem[int'(mem_addr)] : 36'hbadbadbad;

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < SIZE; i++) sim_mem[i] <= '0;
            sim_mem['h13] <= 36'h123456789;
        end else if (int'(mem_addr) < SIZE) begin
            for (int i = 0; i < NBYTES; i++)
                if (mem_wea[i]) sim_mem[int'(mem_addr)][i*LW +: LW] <= mem_din[i*LW +: LW];
        end
    end

    always @(negedge clk) begin
        if (ack == 2'b11) dbl_acks++;
        if (mem_wea != '0 && !busy) wea_idle++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic vec_t mk(input logic [0:1] r, input logic [0:1] w,
                                input logic [0:AW-1] a0, input logic [0:AW-1] a1,
                                input logic [0:WIDTH-1] d0, input logic [0:WIDTH-1] d1,
                                input logic [0:NBYTES-1] b0, input logic [0:NBYTES-1] b1,
                                input int port, input logic e, input logic [0:WIDTH-1] rd);
        vec_t v;
        v.r = r; v.w = w; v.a0 = a0; v.a1 = a1; v.d0 = d0; v.d1 = d1;
        v.b0 = b0; v.b1 = b1; v.port = port; v.e = e; v.rd = rd;
        return v;
    endfunction

    function automatic logic [0:WIDTH-1] merge(input logic [0:WIDTH-1] old_d,
                                               input logic [0:WIDTH-1] nd,
                                               input logic [0:NBYTES-1] b);
        logic [0:WIDTH-1] res = old_d;
        for (int i = 0; i < NBYTES; i++)
            if (b[i]) res[i*LW +: LW] = nd[i*LW +: LW];
        return res;
    endfunction

    // Transaction-level reference: who wins, what comes back, what gets written.
    task automatic model_access(input vec_t v, output int port, output logic e,
                                output logic [0:WIDTH-1] rd, output logic [0:NBYTES-1] wea);
        int a;
        logic w;
        logic [0:WIDTH-1] d;
        logic [0:NBYTES-1] b;
        if (v.r == 2'b11) port = 1 - ref_last;
        else              port = v.r[0] ? 0 : 1;
        ref_last = port;
        w = v.w[port];
        a = (port == 1) ? int'(v.a1) : int'(v.a0);
        d = (port == 1) ? v.d1 : v.d0;
        b = (port == 1) ? v.b1 : v.b0;
        e = (a >= SIZE);
        rd = e ? '0 : ref_mem[a];
        wea = (w && !e) ? b : '0;
        if (w && !e) ref_mem[a] = merge(ref_mem[a], d, b);
    endtask

    task automatic drive(input vec_t v);
        req = v.r; we = v.w; addr0 = v.a0; addr1 = v.a1;
        wdata0 = v.d0; wdata1 = v.d1; be0 = v.b0; be1 = v.b1;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 10 && busy; i++) @(negedge clk);
    endtask

    task automatic run_txn(input vec_t v, output int port, output logic [0:1] ev,
                           output logic [0:WIDTH-1] rd, output int lat,
                           output logic [0:NBYTES-1] wea_seen, output int nacks, output logic bz);
        wait_idle();
        drive(v);
        port = -1; ev = '0; rd = '0; lat = 0; wea_seen = '0; nacks = 0; bz = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            wea_seen |= mem_wea;
            if (ack != 2'b00) begin
                nacks = (ack == 2'b11) ? 2 : 1;
                port  = ack[0] ? 0 : 1;
                ev    = err;
                rd    = rdata;
                lat   = c;
                bz    = busy;
                break;
            end
        end
        req = 2'b00;
    endtask

    task automatic apply(input string tag, input vec_t v, input int x_port, input logic x_e,
                         input logic [0:WIDTH-1] x_rd, input logic [0:NBYTES-1] x_wea);
        int port, lat, nacks;
        logic [0:1] ev, x_ev;
        logic [0:WIDTH-1] rd;
        logic [0:NBYTES-1] ws;
        logic bz;
        run_txn(v, port, ev, rd, lat, ws, nacks, bz);
        x_ev = '0;
        x_ev[x_port] = x_e;
        check({tag, " port"}, port, x_port);
        check({tag, " err"}, ev, x_ev);
        check({tag, " rdata"}, rd, x_rd);
        check({tag, " latency"}, lat, 2);
        check({tag, " ack count"}, nacks, 1);
        check({tag, " mem_wea"}, ws, x_wea);
        check({tag, " busy in DONE"}, bz, 1'b1);
        @(negedge clk);
        check({tag, " ack pulse"}, ack, 2'b00);
        check({tag, " rdata hold"}, rdata, x_rd);
    endtask

    initial begin
        vec_t tbl [12];
        vec_t v;
        int xp, got, n, c;
        logic xe;
        logic [0:WIDTH-1] xrd;
        logic [0:NBYTES-1] xw;
        logic [0:1] x_ack;

        tbl[0]  = mk(2'b10, 2'b00, 8'h13, 8'h00, '0, '0, '0, '0, 0, 1'b0, 36'h123456789);
        tbl[1]  = mk(2'b01, 2'b01, 8'h00, 8'h07, '0, 36'h111111111, '0, 3'b111, 1, 1'b0, 36'h0);
        tbl[2]  = mk(2'b01, 2'b01, 8'h00, 8'h07, '0, 36'h222dddccc, '0, 3'b100, 1, 1'b0, 36'h111111111);
        tbl[3]  = mk(2'b01, 2'b00, 8'h00, 8'h07, '0, '0, '0, '0, 1, 1'b0, 36'h222111111);
        tbl[4]  = mk(2'b10, 2'b10, 8'd100, 8'h00, 36'hfffffffff, '0, 3'b111, '0, 0, 1'b1, 36'h0);
        tbl[5]  = mk(2'b10, 2'b10, 8'h07, 8'h00, '0, '0, 3'b000, '0, 0, 1'b0, 36'h222111111);
        tbl[6]  = mk(2'b11, 2'b00, 8'h13, 8'h07, '0, '0, '0, '0, 1, 1'b0, 36'h222111111);
        tbl[7]  = mk(2'b11, 2'b00, 8'h07, 8'h13, '0, '0, '0, '0, 0, 1'b0, 36'h222111111);
        tbl[8]  = mk(2'b01, 2'b00, 8'h00, 8'hff, '0, '0, '0, '0, 1, 1'b1, 36'h0);
        tbl[9]  = mk(2'b10, 2'b10, 8'd99, 8'h00, 36'habcdef012, '0, 3'b011, '0, 0, 1'b0, 36'h0);
        tbl[10] = mk(2'b01, 2'b00, 8'h00, 8'd99, '0, '0, '0, '0, 1, 1'b0, 36'h000def012);
        tbl[11] = mk(2'b10, 2'b00, 8'd100, 8'h00, '0, '0, '0, '0, 0, 1'b1, 36'h0);

        for (int i = 0; i < SIZE; i++) ref_mem[i] = '0;
        ref_mem['h13] = 36'h123456789;
        ref_last = 1;

        reset = 1'b1; mem_init = 1'b1;
        drive(mk(2'b00, 2'b00, '0, '0, '0, '0, '0, '0, 0, 1'b0, '0));
        repeat (3) @(negedge clk);
        reset = 1'b0; mem_init = 1'b0;
        @(negedge clk);
        check("reset ack", ack, 2'b00);
        check("reset err", err, 2'b00);
        check("reset busy", busy, 1'b0);
        check("reset mem_wea", mem_wea, 3'b000);
        check("reset rdata", rdata, 36'h0);

        for (int i = 0; i < 12; i++) begin
            model_access(tbl[i], xp, xe, xrd, xw);
            apply($sformatf("vec%0d", i), tbl[i], tbl[i].port, tbl[i].e, tbl[i].rd, xw);
        end

        // Request dropped right after the grant still completes.
        wait_idle();
        v = mk(2'b10, 2'b00, 8'h13, 8'h00, '0, '0, '0, '0, 0, 1'b0, '0);
        model_access(v, xp, xe, xrd, xw);
        drive(v);
        @(negedge clk);
        req = 2'b00;
        @(negedge clk);
        check("drop ack", ack, 2'b10);
        check("drop rdata", rdata, xrd);

        // A request raised during GRANT waits for the next IDLE.
        wait_idle();
        v = mk(2'b10, 2'b00, 8'h07, 8'd99, '0, '0, '0, '0, 0, 1'b0, '0);
        model_access(v, xp, xe, xrd, xw);
        drive(v);
        @(negedge clk);
        req = 2'b11;
        @(negedge clk);
        check("late0 ack", ack, 2'b10);
        check("late0 rdata", rdata, xrd);
        req = 2'b01;
        v.r = 2'b01;
        model_access(v, xp, xe, xrd, xw);
        got = -1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (ack != 2'b00) begin
                got = k;
                break;
            end
        end
        check("late1 wait", got, 3);
        check("late1 ack", ack, 2'b01);
        check("late1 rdata", rdata, xrd);
        req = 2'b00;

        // Both ports held continuously: grants alternate.
        wait_idle();
        v = mk(2'b11, 2'b00, 8'h13, 8'h07, '0, '0, '0, '0, 0, 1'b0, '0);
        drive(v);
        n = 0;
        c = 0;
        while (n < 4 && c < 20) begin
            @(negedge clk);
            c++;
            if (ack != 2'b00) begin
                model_access(v, xp, xe, xrd, xw);
                x_ack = '0;
                x_ack[xp] = 1'b1;
                check($sformatf("alt%0d ack", n), ack, x_ack);
                check($sformatf("alt%0d rdata", n), rdata, xrd);
                n++;
            end
        end
        req = 2'b00;
        check("alt count", n, 4);

        // Reset during GRANT cancels the write and the ack.
        wait_idle();
        v = mk(2'b10, 2'b10, 8'h07, 8'h00, 36'heeeeeeeee, '0, 3'b111, '0, 0, 1'b0, '0);
        drive(v);
        @(negedge clk);
        check("rst grant wea", mem_wea, 3'b111);
        reset = 1'b1;
        #1;
        check("rst wea cut", mem_wea, 3'b000);
        @(negedge clk);
        reset = 1'b0;
        req = 2'b00;
        ref_last = 1;
        check("rst mem7", sim_mem[7], ref_mem[7]);
        check("rst rdata", rdata, 36'h0);
        check("rst busy", busy, 1'b0);
        got = 0;
        repeat (4) begin
            @(negedge clk);
            if (ack != 2'b00) got++;
        end
        check("rst no ack", got, 0);
        v = mk(2'b10, 2'b00, 8'h07, 8'h00, '0, '0, '0, '0, 0, 1'b0, '0);
        model_access(v, xp, xe, xrd, xw);
        apply("post rst", v, xp, xe, xrd, xw);

        for (int i = 0; i < 60; i++) begin
            int pat;
            pat = $urandom_range(0, 2);
            v.r  = (pat == 0) ? 2'b10 : (pat == 1) ? 2'b01 : 2'b11;
            v.w  = 2'($urandom);
            v.a0 = 8'($urandom_range(0, 115));
            v.a1 = 8'($urandom_range(0, 115));
            v.d0 = 36'({$urandom, $urandom});
            v.d1 = 36'({$urandom, $urandom});
            v.b0 = 3'($urandom);
            v.b1 = 3'($urandom);
            model_access(v, xp, xe, xrd, xw);
            apply($sformatf("rnd%0d", i), v, xp, xe, xrd, xw);
        end

        check("double acks", dbl_acks, 0);
        check("wea outside GRANT/DONE", wea_idle, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
